// File: rtl/lfsr_stream_checker_if.sv
// Signal bundle between the stream source/controller and the LFSR stream checker.
// The master drives taps and stream bits; the slave (checker) returns status.
interface lfsr_stream_checker_if #(
   parameter int WIDTH = 8,
   parameter int ERR_W = 8
);
   logic             taps_load;
   logic [WIDTH-1:0] taps_in;
   logic             bit_valid;
   logic             bit_in;
   logic             locked;
   logic             err_pulse;
   logic [ERR_W-1:0] err_count;
   logic             zero_trap;

   modport master (
      output taps_load, taps_in, bit_valid, bit_in,
      input  locked, err_pulse, err_count, zero_trap
   );

   modport slave (
      input  taps_load, taps_in, bit_valid, bit_in,
      output locked, err_pulse, err_count, zero_trap
   );
endinterface

// File: rtl/lfsr_stream_checker.sv
// Self-synchronising checker for a programmable-tap LFSR serial stream.
// Hunts for WIDTH bits, verifies LOCK_COUNT predictions, then counts errors while locked.
module lfsr_stream_checker #(
   parameter int               WIDTH        = 8,
   parameter logic [WIDTH-1:0] DEFAULT_TAPS = 8'hB8,
   parameter int               LOCK_COUNT   = 8,
   parameter int               LOSS_THRESH  = 4,
   parameter int               ERR_W        = 8
) (
   input logic                  clk,
   input logic                  rst_n,
   lfsr_stream_checker_if.slave bus
);
   localparam int FILL_W  = $clog2(WIDTH + 1);
   localparam int MATCH_W = $clog2(LOCK_COUNT + 1);
   localparam int MISS_W  = $clog2(LOSS_THRESH + 1);

   localparam logic [FILL_W-1:0]  FILL_LAST  = FILL_W'(WIDTH - 1);
   localparam logic [MATCH_W-1:0] MATCH_LAST = MATCH_W'(LOCK_COUNT - 1);
   localparam logic [MISS_W-1:0]  MISS_LAST  = MISS_W'(LOSS_THRESH - 1);

   typedef enum logic [1:0] {
      ST_HUNT,
      ST_VERIFY,
      ST_LOCKED
   } state_e;

   state_e             state_q, state_d;
   logic [WIDTH-1:0]   taps_q, taps_d;
   logic [WIDTH-1:0]   hist_q, hist_d;
   logic [FILL_W-1:0]  fill_q, fill_d;
   logic [MATCH_W-1:0] match_q, match_d;
   logic [MISS_W-1:0]  miss_q, miss_d;
   logic [ERR_W-1:0]   err_count_q, err_count_d;
   logic               locked_q, locked_d;
   logic               err_pulse_q, err_pulse_d;
   logic               zero_trap_q, zero_trap_d;

   logic [WIDTH-1:0]   hist_shift;
   logic               pred;
   logic               bit_match;
   logic               hist_zero;

   // The received bit is what enters the history, so the checker resynchronises by itself.
   assign hist_shift = {hist_q[WIDTH-2:0], bus.bit_in};
   assign pred       = ^(hist_q & taps_q);
   assign bit_match  = (bus.bit_in == pred);
   assign hist_zero  = (hist_shift == '0);

   always_comb begin
      // NOTE: every *_d gets its hold value first, so no branch can leave one unassigned and infer a latch.
      state_d     = state_q;
      taps_d      = taps_q;
      hist_d      = hist_q;
      fill_d      = fill_q;
      match_d     = match_q;
      miss_d      = miss_q;
      err_count_d = err_count_q;
      zero_trap_d = zero_trap_q;
      err_pulse_d = 1'b0;

      if (bus.taps_load) begin
         taps_d      = bus.taps_in;
         hist_d      = '0;
         state_d     = ST_HUNT;
         fill_d      = '0;
         match_d     = '0;
         miss_d      = '0;
         err_count_d = '0;
         zero_trap_d = 1'b0;
      end else if (bus.bit_valid) begin
         hist_d = hist_shift;
         unique case (state_q)
            ST_HUNT: begin
               fill_d = fill_q + 1'b1;
               if (fill_q == FILL_LAST) begin
                  state_d = ST_VERIFY;
                  fill_d  = '0;
                  match_d = '0;
               end
            end
            ST_VERIFY: begin
               if (!bit_match) begin
                  match_d = '0;
               end else if (hist_zero) begin
                  zero_trap_d = 1'b1;
                  state_d     = ST_HUNT;
                  match_d     = '0;
               end else if (match_q == MATCH_LAST) begin
                  state_d = ST_LOCKED;
                  match_d = '0;
                  miss_d  = '0;
               end else begin
                  match_d = match_q + 1'b1;
               end
            end
            ST_LOCKED: begin
               miss_d = '0;
               if (!bit_match) begin
                  err_pulse_d = 1'b1;
                  miss_d      = miss_q + 1'b1;
                  if (err_count_q != '1) err_count_d = err_count_q + 1'b1;
               end
               // The losing bit has already pulsed and counted above.
               if (hist_zero) begin
                  zero_trap_d = 1'b1;
                  state_d     = ST_HUNT;
                  miss_d      = '0;
               end else if (!bit_match && (miss_q == MISS_LAST)) begin
                  state_d = ST_HUNT;
                  miss_d  = '0;
               end
            end
            default: state_d = ST_HUNT;
         endcase
      end

      locked_d = (state_d == ST_LOCKED);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_HUNT;
         taps_q      <= DEFAULT_TAPS;
         hist_q      <= '0;
         fill_q      <= '0;
         match_q     <= '0;
         miss_q      <= '0;
         err_count_q <= '0;
         locked_q    <= 1'b0;
         err_pulse_q <= 1'b0;
         zero_trap_q <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples the pre-edge values of the others.
         state_q     <= state_d;
         taps_q      <= taps_d;
         hist_q      <= hist_d;
         fill_q      <= fill_d;
         match_q     <= match_d;
         miss_q      <= miss_d;
         err_count_q <= err_count_d;
         locked_q    <= locked_d;
         err_pulse_q <= err_pulse_d;
         zero_trap_q <= zero_trap_d;
      end
   end

   assign bus.locked    = locked_q;
   assign bus.err_pulse = err_pulse_q;
   assign bus.err_count = err_count_q;
   assign bus.zero_trap = zero_trap_q;
endmodule

// File: tb/tb_lfsr_stream_checker.sv
// Bench for lfsr_stream_checker: directed scenarios plus randomized streams,
// each step compared against a history-array model of the checker's rules.
module tb_lfsr_stream_checker;
   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   lfsr_stream_checker_if #(.WIDTH(8), .ERR_W(8)) bus ();

   lfsr_stream_checker #(
      .WIDTH(8), .DEFAULT_TAPS(8'hB8), .LOCK_COUNT(8), .LOSS_THRESH(4), .ERR_W(8)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   int errors = 0;
   int checks = 0;

   // Reference model: full received history since the last restart.
   logic [7:0] m_taps;
   bit         rx[$];
   int         m_mode;   // 0 hunting, 1 verifying, 2 locked
   int         m_fill, m_match, m_miss;
   logic       m_locked, m_pulse, m_trap;
   logic [7:0] m_count;

   // Transmit-side generator.
   logic [7:0] g_taps, g_state;

   function automatic bit rx_at(int k);
      return (k >= 0 && k < rx.size()) ? rx[k] : 1'b0;
   endfunction

   task automatic model_clear(input logic [7:0] t);
      m_taps = t;
      rx.delete();
      m_mode = 0; m_fill = 0; m_match = 0; m_miss = 0;
      m_locked = 1'b0; m_pulse = 1'b0; m_trap = 1'b0; m_count = 8'h00;
   endtask

   task automatic model_step(input logic load, input logic [7:0] tin, input logic valid, input logic b);
      int n;
      bit p, allz, hit;
      m_pulse = 1'b0;
      if (load) begin
         model_clear(tin);
         return;
      end
      if (!valid) return;
      n = rx.size();
      p = 1'b0;
      for (int i = 0; i < 8; i++) if (m_taps[i]) p ^= rx_at(n - 1 - i);
      rx.push_back(b);
      allz = 1'b1;
      for (int i = 0; i < 8; i++) if (rx_at(n - i)) allz = 1'b0;
      hit = (b == p);
      case (m_mode)
         0: begin
            m_fill++;
            if (m_fill == 8) begin m_mode = 1; m_match = 0; m_fill = 0; end
         end
         1: begin
            if (hit && allz) begin m_trap = 1'b1; m_mode = 0; m_fill = 0; m_match = 0; end
            else if (hit) begin
               m_match++;
               if (m_match == 8) begin m_mode = 2; m_miss = 0; m_match = 0; end
            end else m_match = 0;
         end
         default: begin
            if (!hit) begin
               m_pulse = 1'b1;
               m_count = (m_count == 8'hFF) ? 8'hFF : m_count + 8'd1;
               m_miss++;
            end else m_miss = 0;
            if (allz) begin m_trap = 1'b1; m_mode = 0; m_fill = 0; m_miss = 0; end
            else if (m_miss == 4) begin m_mode = 0; m_fill = 0; m_miss = 0; end
         end
      endcase
      m_locked = (m_mode == 2);
   endtask

   task automatic step(input logic load, input logic [7:0] tin, input logic valid, input logic b);
      bus.taps_load = load;
      bus.taps_in   = tin;
      bus.bit_valid = valid;
      bus.bit_in    = b;
      @(posedge clk);
      #1;
      model_step(load, tin, valid, b);
      bus.taps_load = 1'b0;
      bus.bit_valid = 1'b0;
   endtask

   task automatic gen_bit(input bit flip, input bit resync, output logic sent);
      logic b;
      b       = ^(g_state & g_taps);
      g_state = {g_state[6:0], b};
      sent    = b ^ flip;
      if (resync) g_state[0] = sent;
   endtask

   function automatic bit flip_safe();
      logic [7:0] nxt;
      nxt = {g_state[6:0], ~(^(g_state & g_taps))};
      return nxt != 8'h00;
   endfunction

   task automatic do_reset();
      bus.taps_load = 1'b0; bus.taps_in = 8'h00; bus.bit_valid = 1'b0; bus.bit_in = 1'b0;
      @(negedge clk); rst_n = 1'b0;
      @(negedge clk); rst_n = 1'b1;
      model_clear(8'hB8);
   endtask

   task automatic test_reset();
      bus.taps_load = 1'b0; bus.taps_in = 8'h00; bus.bit_valid = 1'b1; bus.bit_in = 1'b1;
      #1 rst_n = 1'b0;
      #1;
      checks++;
      if ({bus.locked, bus.err_pulse, bus.err_count, bus.zero_trap} !== 11'h000) begin
         errors++;
         $display("FAIL reset_async: got %h want 000", {bus.locked, bus.err_pulse, bus.err_count, bus.zero_trap});
      end
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({bus.locked, bus.err_pulse, bus.err_count, bus.zero_trap} !== 11'h000) begin
         errors++;
         $display("FAIL reset_held: got %h want 000", {bus.locked, bus.err_pulse, bus.err_count, bus.zero_trap});
      end
      bus.bit_valid = 1'b0;
      @(negedge clk); rst_n = 1'b1;
      model_clear(8'hB8);
   endtask

   task automatic test_lock();
      logic s;
      do_reset();
      g_taps = 8'hB8; g_state = 8'h01;
      for (int n = 1; n <= 200; n++) begin
         gen_bit(1'b0, 1'b0, s);
         step(1'b0, 8'h00, 1'b1, s);
         checks++;
         if (bus.locked !== (n >= 16)) begin
            errors++;
            $display("FAIL lock_time bit %0d: locked=%b want %b", n, bus.locked, (n >= 16));
         end
         checks++;
         if ({bus.locked, bus.err_pulse, bus.err_count, bus.zero_trap} !== {m_locked, m_pulse, m_count, m_trap}) begin
            errors++;
            $display("FAIL lock_model bit %0d: got %h want %h", n,
                     {bus.locked, bus.err_pulse, bus.err_count, bus.zero_trap}, {m_locked, m_pulse, m_count, m_trap});
         end
      end
      checks++;
      if (bus.err_count !== 8'd0) begin
         errors++;
         $display("FAIL lock_err_count: got %0d want 0", bus.err_count);
      end
   endtask

   task automatic test_single_error();
      logic s;
      bit exp_p;
      do_reset();
      g_taps = 8'hB8; g_state = 8'h01;
      for (int n = 1; n <= 60; n++) begin
         gen_bit(n == 40, 1'b0, s);
         step(1'b0, 8'h00, 1'b1, s);
         exp_p = (n == 40 || n == 44 || n == 45 || n == 46 || n == 48);
         checks++;
         if (bus.err_pulse !== exp_p || bus.locked !== (n >= 16)) begin
            errors++;
            $display("FAIL single_err bit %0d: pulse=%b locked=%b want %b %b", n, bus.err_pulse, bus.locked, exp_p, (n >= 16));
         end
         checks++;
         if ({bus.locked, bus.err_pulse, bus.err_count, bus.zero_trap} !== {m_locked, m_pulse, m_count, m_trap}) begin
            errors++;
            $display("FAIL single_model bit %0d: got %h want %h", n,
                     {bus.locked, bus.err_pulse, bus.err_count, bus.zero_trap}, {m_locked, m_pulse, m_count, m_trap});
         end
      end
      checks++;
      if (bus.err_count !== 8'd5) begin
         errors++;
         $display("FAIL single_err_count: got %0d want 5", bus.err_count);
      end
   endtask

   task automatic test_loss_of_lock();
      logic s;
      logic [7:0] peek;
      bit found, pb, zeros;
      do_reset();
      g_taps = 8'hB8; g_state = 8'($urandom_range(1, 255));
      for (int n = 1; n <= 16; n++) begin
         gen_bit(1'b0, 1'b0, s);
         step(1'b0, 8'h00, 1'b1, s);
      end
      checks++;
      if (bus.locked !== 1'b1) begin
         errors++;
         $display("FAIL loss_prelock: locked=%b want 1", bus.locked);
      end
      // Switch over where the true stream would have carried four zeros.
      found = 1'b0;
      for (int k = 0; k < 300 && !found; k++) begin
         peek = g_state; zeros = 1'b1;
         for (int j = 0; j < 4; j++) begin
            pb = ^(peek & g_taps); peek = {peek[6:0], pb};
            if (pb) zeros = 1'b0;
         end
         if (zeros) found = 1'b1;
         else begin
            gen_bit(1'b0, 1'b0, s);
            step(1'b0, 8'h00, 1'b1, s);
         end
      end
      checks++;
      if (!found) begin
         errors++;
         $display("FAIL loss_search: no zero run found within budget");
      end
      for (int k = 1; k <= 4; k++) begin
         step(1'b0, 8'h00, 1'b1, 1'b1);
         checks++;
         if (bus.err_pulse !== 1'b1 || bus.err_count !== 8'(k) || bus.locked !== (k < 4)) begin
            errors++;
            $display("FAIL loss_ones %0d: pulse=%b count=%0d locked=%b want 1 %0d %b",
                     k, bus.err_pulse, bus.err_count, bus.locked, k, (k < 4));
         end
         checks++;
         if ({bus.locked, bus.err_pulse, bus.err_count, bus.zero_trap} !== {m_locked, m_pulse, m_count, m_trap}) begin
            errors++;
            $display("FAIL loss_model %0d: got %h want %h", k,
                     {bus.locked, bus.err_pulse, bus.err_count, bus.zero_trap}, {m_locked, m_pulse, m_count, m_trap});
         end
      end
   endtask

   task automatic test_zero_trap();
      do_reset();
      for (int n = 1; n <= 24; n++) begin
         step(1'b0, 8'h00, 1'b1, 1'b0);
         checks++;
         if (bus.locked !== 1'b0 || bus.zero_trap !== (n >= 9)) begin
            errors++;
            $display("FAIL zero_trap bit %0d: locked=%b trap=%b want 0 %b", n, bus.locked, bus.zero_trap, (n >= 9));
         end
         checks++;
         if ({bus.locked, bus.err_pulse, bus.err_count, bus.zero_trap} !== {m_locked, m_pulse, m_count, m_trap}) begin
            errors++;
            $display("FAIL zero_model bit %0d: got %h want %h", n,
                     {bus.locked, bus.err_pulse, bus.err_count, bus.zero_trap}, {m_locked, m_pulse, m_count, m_trap});
         end
      end
   endtask

   task automatic test_taps_load();
      logic s;
      step(1'b1, 8'h8E, 1'b1, 1'b1);
      checks++;
      if ({bus.locked, bus.err_pulse, bus.err_count, bus.zero_trap} !== 11'h000) begin
         errors++;
         $display("FAIL taps_load_clear: got %h want 000", {bus.locked, bus.err_pulse, bus.err_count, bus.zero_trap});
      end
      g_taps = 8'h8E; g_state = 8'($urandom_range(1, 255));
      for (int n = 1; n <= 24; n++) begin
         gen_bit(1'b0, 1'b0, s);
         step(1'b0, 8'h00, 1'b1, s);
         checks++;
         if (bus.locked !== (n >= 16)) begin
            errors++;
            $display("FAIL taps_8e_lock bit %0d: locked=%b want %b", n, bus.locked, (n >= 16));
         end
         checks++;
         if ({bus.locked, bus.err_pulse, bus.err_count, bus.zero_trap} !== {m_locked, m_pulse, m_count, m_trap}) begin
            errors++;
            $display("FAIL taps_model bit %0d: got %h want %h", n,
                     {bus.locked, bus.err_pulse, bus.err_count, bus.zero_trap}, {m_locked, m_pulse, m_count, m_trap});
         end
      end
   endtask

   task automatic test_async_reset();
      logic s;
      int nv;
      do_reset();
      g_taps = 8'hB8; g_state = 8'($urandom_range(1, 255));
      for (int n = 0; n < 20; n++) begin
         gen_bit(1'b0, 1'b1, s);
         step(1'b0, 8'h00, 1'b1, s);
      end
      for (int e = 0; e < 3; e++) begin
         for (int g = 0; g < 10 && !flip_safe(); g++) begin
            gen_bit(1'b0, 1'b1, s);
            step(1'b0, 8'h00, 1'b1, s);
         end
         gen_bit(1'b1, 1'b1, s);
         step(1'b0, 8'h00, 1'b1, s);
         repeat (2) begin
            gen_bit(1'b0, 1'b1, s);
            step(1'b0, 8'h00, 1'b1, s);
         end
      end
      checks++;
      if (bus.err_count !== 8'd3 || bus.locked !== 1'b1) begin
         errors++;
         $display("FAIL arst_setup: count=%0d locked=%b want 3 1", bus.err_count, bus.locked);
      end
      #3 rst_n = 1'b0;
      #1;
      checks++;
      if ({bus.locked, bus.err_pulse, bus.err_count, bus.zero_trap} !== 11'h000) begin
         errors++;
         $display("FAIL arst_immediate: got %h want 000", {bus.locked, bus.err_pulse, bus.err_count, bus.zero_trap});
      end
      model_clear(8'hB8);
      @(negedge clk); rst_n = 1'b1;
      nv = 0;
      for (int c = 0; c < 400 && nv < 24; c++) begin
         if ($urandom_range(0, 1) == 1) begin
            gen_bit(1'b0, 1'b0, s);
            step(1'b0, 8'h00, 1'b1, s);
            nv++;
         end else begin
            step(1'b0, 8'h00, 1'b0, 1'($urandom_range(0, 1)));
         end
         checks++;
         if (bus.locked !== (nv >= 16)) begin
            errors++;
            $display("FAIL arst_relock valid %0d: locked=%b want %b", nv, bus.locked, (nv >= 16));
         end
         checks++;
         if ({bus.locked, bus.err_pulse, bus.err_count, bus.zero_trap} !== {m_locked, m_pulse, m_count, m_trap}) begin
            errors++;
            $display("FAIL arst_model cyc %0d: got %h want %h", c,
                     {bus.locked, bus.err_pulse, bus.err_count, bus.zero_trap}, {m_locked, m_pulse, m_count, m_trap});
         end
      end
      checks++;
      if (nv < 24) begin
         errors++;
         $display("FAIL arst_budget: only %0d valid bits sent, want 24", nv);
      end
   endtask

   task automatic test_saturation();
      logic s;
      int flips;
      do_reset();
      g_taps = 8'hB8; g_state = 8'($urandom_range(1, 255));
      for (int n = 0; n < 16; n++) begin
         gen_bit(1'b0, 1'b1, s);
         step(1'b0, 8'h00, 1'b1, s);
      end
      flips = 0;
      for (int c = 0; c < 1000 && flips < 262; c++) begin
         if (c[0] && flip_safe()) begin
            gen_bit(1'b1, 1'b1, s);
            flips++;
         end else gen_bit(1'b0, 1'b1, s);
         step(1'b0, 8'h00, 1'b1, s);
         checks++;
         if ({bus.locked, bus.err_pulse, bus.err_count, bus.zero_trap} !== {m_locked, m_pulse, m_count, m_trap}) begin
            errors++;
            $display("FAIL sat_model cyc %0d: got %h want %h", c,
                     {bus.locked, bus.err_pulse, bus.err_count, bus.zero_trap}, {m_locked, m_pulse, m_count, m_trap});
         end
      end
      checks++;
      if (bus.err_count !== 8'hFF || bus.locked !== 1'b1 || flips < 262) begin
         errors++;
         $display("FAIL sat_hold: count=%0d locked=%b flips=%0d want 255 1 262", bus.err_count, bus.locked, flips);
      end
   endtask

   task automatic test_random();
      logic s;
      logic [7:0] t;
      int r;
      do_reset();
      g_taps = 8'hB8; g_state = 8'($urandom_range(1, 255));
      for (int c = 0; c < 1500; c++) begin
         r = $urandom_range(0, 99);
         if (r < 2) begin
            t = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            step(1'b1, t, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            g_taps = t; g_state = 8'($urandom_range(1, 255));
         end else if (r < 22) begin
            step(1'b0, 8'($urandom), 1'b0, 1'($urandom_range(0, 1)));
         end else begin
            gen_bit(r < 26, 1'($urandom_range(0, 1)), s);
            step(1'b0, 8'($urandom), 1'b1, s);
         end
         checks++;
         if ({bus.locked, bus.err_pulse, bus.err_count, bus.zero_trap} !== {m_locked, m_pulse, m_count, m_trap}) begin
            errors++;
            $display("FAIL random_model cyc %0d: got %h want %h", c,
                     {bus.locked, bus.err_pulse, bus.err_count, bus.zero_trap}, {m_locked, m_pulse, m_count, m_trap});
         end
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_lock();
      test_single_error();
      test_loss_of_lock();
      test_zero_trap();
      test_taps_load();
      test_async_reset();
      test_saturation();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
